// File: rtl/booth_arb_pkg.sv
// Shared types and widths for the Booth multiplier arbiter and its datapath.
package booth_arb_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/modified_booth_multiplier.sv
// Combinational signed 8x8 radix-4 Booth multiplier producing a full 16-bit product.
module modified_booth_multiplier
  import booth_arb_pkg::*;
(
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic signed [PROD_W-1:0] product
);

  logic [OP_W:0] b_ext;

  // Implicit zero below the LSB seeds the first Booth triplet.
  assign b_ext = {b, 1'b0};

  always_comb begin
    logic signed [PROD_W-1:0] a_w;
    logic signed [PROD_W-1:0] pp;
    logic signed [PROD_W-1:0] acc;
    a_w = PROD_W'(a);
    acc = '0;
    for (int i = 0; i < int'(OP_W / 2); i++) begin
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: pp = a_w;
        3'b011:         pp = a_w <<< 1;
        3'b100:         pp = -(a_w <<< 1);
        3'b101, 3'b110: pp = -a_w;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2 * i));
    end
    product = acc;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant finder: first valid index at or after ptr, modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_valid
);

  logic [2*NUM_REQ-1:0] rot;

  always_comb begin
    rot       = {valid, valid} >> ptr;
    grant     = '0;
    any_valid = |valid;
    // Descending walk: the offset nearest ptr is written last and wins.
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant = ID_W'((int'(ptr) + k) % int'(NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one registered Booth multiplier among NUM_REQ requesters.
// Optional BOOTH_ARB_PRIO0_EN: requester 0 takes strict priority over the round-robin set.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [PROD_W-1:0]       res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy
);

  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [OP_W-1:0]     op_a_q;
  logic [OP_W-1:0]     op_b_q;
  logic [ID_W-1:0]     op_id_q;
  logic                res_valid_q;
  logic [PROD_W-1:0]   res_data_q;
  logic [ID_W-1:0]     res_id_q;

  logic [NUM_REQ-1:0]  arb_valid;
  logic [ID_W-1:0]     rr_grant;
  logic                rr_any;
  logic [ID_W-1:0]     grant;
  logic                any_req;
  logic                upd_ptr;
  logic [ID_W-1:0]     next_ptr;
  logic [OP_W-1:0]     sel_a;
  logic [OP_W-1:0]     sel_b;
  logic signed [PROD_W-1:0] product;

`ifdef BOOTH_ARB_PRIO0_EN
  assign arb_valid = {req_valid[NUM_REQ-1:1], 1'b0};
`else
  assign arb_valid = req_valid;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .valid     (arb_valid),
    .ptr       (rr_ptr_q),
    .grant     (rr_grant),
    .any_valid (rr_any)
  );

  always_comb begin
`ifdef BOOTH_ARB_PRIO0_EN
    // A priority grant to requester 0 leaves the rotation of the others untouched.
    if (req_valid[0]) begin
      grant   = '0;
      any_req = 1'b1;
      upd_ptr = 1'b0;
    end else begin
      grant   = rr_grant;
      any_req = rr_any;
      upd_ptr = 1'b1;
    end
`else
    grant   = rr_grant;
    any_req = rr_any;
    upd_ptr = 1'b1;
`endif
    next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant == ID_W'(i)) begin
        req_ready[i] = (state_q == ST_IDLE) && any_req;
        sel_a        = req_a[i*OP_W +: OP_W];
        sel_b        = req_b[i*OP_W +: OP_W];
      end
    end
  end

  modified_booth_multiplier u_mult (
    .a       (op_a_q),
    .b       (op_b_q),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
            op_id_q <= grant;
            if (upd_ptr) begin
              rr_ptr_q <= next_ptr;
            end
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_data_q  <= product;
          res_id_q    <= op_id_q;
          res_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomized bench for booth_mult_arbiter with a transaction-level reference model.
module tb_booth_mult_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [8*NUM_REQ-1:0]   req_a;
  logic [8*NUM_REQ-1:0]   req_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [15:0]            res_data;
  logic [ID_W-1:0]        res_id;
  logic                   busy;

  int n_chk  = 0;
  int n_pass = 0;

  booth_mult_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: an op is granted, spends one cycle in the multiplier, then waits on res_ready.
  int          m_phase = 0;  // 0 free, 1 computing, 2 result offered
  int          m_ptr   = 0;
  logic [15:0] m_data;
  int          m_id;

  function automatic int exp_grant(logic [NUM_REQ-1:0] v, int ptr);
`ifdef BOOTH_ARB_PRIO0_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_res_data", 32'(res_data), 0);
      check("rst_res_id", 32'(res_id), 0);
      m_phase = 0;
      m_ptr   = 0;
    end else begin
      case (m_phase)
        0: begin
          int g;
          logic signed [7:0]  sa;
          logic signed [7:0]  sb;
          logic signed [15:0] p;
          g = exp_grant(req_valid, m_ptr);
          check("idle_req_ready", 32'(req_ready), (g < 0) ? 0 : (32'd1 << g));
          check("idle_busy", 32'(busy), 0);
          check("idle_res_valid", 32'(res_valid), 0);
          if (g >= 0) begin
            sa      = req_a[8*g +: 8];
            sb      = req_b[8*g +: 8];
            p       = sa * sb;
            m_data  = p;
            m_id    = g;
            m_phase = 1;
`ifdef BOOTH_ARB_PRIO0_EN
            if (g != 0) m_ptr = (g + 1) % NUM_REQ;
`else
            m_ptr = (g + 1) % NUM_REQ;
`endif
          end
        end
        1: begin
          check("exec_req_ready", 32'(req_ready), 0);
          check("exec_busy", 32'(busy), 1);
          check("exec_res_valid", 32'(res_valid), 0);
          m_phase = 2;
        end
        default: begin
          check("resp_res_valid", 32'(res_valid), 1);
          check("resp_res_data", 32'(res_data), 32'(m_data));
          check("resp_res_id", 32'(res_id), 32'(m_id));
          check("resp_req_ready", 32'(req_ready), 0);
          check("resp_busy", 32'(busy), 1);
          if (res_ready) m_phase = 0;
        end
      endcase
    end
  end

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'hFF;
      3:       return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic set_op(int i, logic [7:0] a, logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  // Present one op on requester i and withdraw it right after the accepting edge.
  task automatic issue(int i, logic [7:0] a, logic [7:0] b);
    bit done = 1'b0;
    set_op(i, a, b);
    req_valid[i] = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (req_ready[i]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid[i] = 1'b0;
    check("issue_accepted", 32'(done), 1);
  endtask

  // persist=1: accepted requesters immediately re-request; persist=0: random traffic.
  task automatic run_cycles(int n, bit persist);
    logic [NUM_REQ-1:0] acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          if (persist) set_op(i, rnd_op(), rnd_op());
          else begin
            req_valid[i] = ($urandom_range(0, 1) == 1);
            set_op(i, rnd_op(), rnd_op());
          end
        end else if (!req_valid[i]) begin
          if (!persist && $urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            set_op(i, rnd_op(), rnd_op());
          end
        end else if (!persist && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if (!persist) res_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;

    issue(0, 8'd10, 8'd10);
    issue(1, 8'h80, 8'h80);
    issue(2, 8'hF6, 8'd10);
    issue(3, 8'h80, 8'd10);
    issue(0, 8'd127, 8'hFF);
    issue(1, 8'h80, 8'd127);
    repeat (4) @(posedge clk);
    #1;

    // Fairness with all requesters persistently requesting.
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'(i + 3), 8'(i * 7 + 1));
    req_valid = '1;
    run_cycles(16, 1'b1);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure while another requester waits.
    res_ready = 1'b0;
    issue(2, 8'd7, 8'hFD);
    set_op(1, 8'd9, 8'd9);
    req_valid[1] = 1'b1;
    repeat (12) @(posedge clk);
    #1 res_ready = 1'b1;
    issue(1, 8'd9, 8'd9);
    repeat (4) @(posedge clk);
    #1;

    // Reset while the op is in the multiplier stage.
    issue(2, 8'd5, 8'd6);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(1, 8'd3, 8'd4);
    repeat (4) @(posedge clk);
    #1;

`ifdef BOOTH_ARB_PRIO0_EN
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'(i + 1), 8'd2);
    req_valid = '1;
    run_cycles(12, 1'b1);
    req_valid[0] = 1'b0;
    run_cycles(12, 1'b1);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
`endif

    run_cycles(400, 1'b0);
    req_valid = '0;
    res_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
